wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Capture buffer for the pipeline core's observation outputs. Each cycle it samples the writeback port (reg_write_sig/reg_num/reg_data) and the data-memory port (wr/rd/addr/wr_data/rd_data) and packs qualifying events into tagged entries. Entries go into a DEPTH-entry FIFO that a debug host or testbench drains over a valid/ready stream. The block sits beside the core, is purely an observer, and never back-pressures it.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥4
- DATA_W, 32, data width; matches core
- ADDR_W, 9, memory address width; matches core
- FILTER_X0, 1, when 1, register writes with reg_num==0 are not recorded
- STOP_ON_FULL, 0, when 1, the first dropped event moves the FSM to STOPPED
- ENTRY_W, localparam, 2+5+ADDR_W+DATA_W (48 at defaults)

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- reg_write_sig  in  1  core writeback strobe
- reg_num  in  5  writeback register index
- reg_data  in  DATA_W  writeback value
- wr  in  1  core memory write strobe
- rd  in  1  core memory read strobe
- addr  in  ADDR_W  memory address
- wr_data  in  DATA_W  store data
- rd_data  in  DATA_W  load data
- arm  in  1  pulse; start capture
- stop  in  1  pulse; stop capture
- clear  in  1  pulse; flush FIFO and zero drop counter
- out_valid  out  1  head entry available
- out_ready  in  1  host accepts head entry
- out_data  out  ENTRY_W  head entry
- count  out  $clog2(DEPTH)+1  entries stored
- dropped  out  16  events lost, saturating
- state  out  2  00 IDLE, 01 CAPTURE, 10 STOPPED

## Operation
- Entry format: [ENTRY_W-1:ENTRY_W-2] kind (01 reg write, 10 mem write, 11 mem read); next 5 bits reg_num (0 for mem kinds); next ADDR_W bits addr (0 for reg kind); low DATA_W bits data (reg_data, wr_data or rd_data).
- Events per cycle: a reg event (reg_write_sig, minus x0 when FILTER_X0) and a mem event (wr, else rd). wr&rd both high records only the write.
- Events are recorded only while state==CAPTURE. Up to two pushes per cycle; order is mem event first, then reg event.
- Free space = DEPTH − count + (pop this cycle). With space 1 and two events, the mem event is stored and the reg event is dropped. Space 0 drops both.
- dropped increments by the number of lost events and saturates at 16'hFFFF.
- FSM:
  - IDLE -arm-> CAPTURE
  - CAPTURE -stop-> STOPPED
  - CAPTURE -drop with STOP_ON_FULL-> STOPPED; the entries that fit that cycle are still stored.
  - STOPPED -arm-> CAPTURE
  - stop and arm in the same cycle: stop wins. arm while in CAPTURE has no effect.
- Pop happens when out_valid&&out_ready. Draining is allowed in any state.
- clear: read/write pointers, count and dropped go to 0. The state is unchanged. clear overrides any push and pop in the same cycle.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.

## Timing
- Reset: state=IDLE, count=0, dropped=0, out_valid=0, out_data=0. FIFO contents are don't-care.
- State changes take effect the cycle after the arm/stop edge. Events in the same cycle as arm are not captured.
- Event sampled at edge N → out_valid=1 and out_data valid after edge N (latency 1) if the FIFO was empty.
- out_data is show-ahead: the head entry is stable while out_valid is high and out_ready is low. It advances the cycle after the pop.
- count/dropped update at the same edge as the push/pop/drop.
- Full FIFO with pop plus one event in the same cycle: the event is stored, count stays DEPTH, dropped is unchanged.
- reset asserted mid-capture discards everything. The next cycle shows reset values.

## Test plan
- Reset, arm, one reg write x5=32'hDEADBEEF → next cycle out_valid=1, out_data={2'b01,5'd5,9'd0,32'hDEADBEEF}, count=1; pulse out_ready → count=0, out_valid=0.
- Same cycle wr=1 addr=9'h10 wr_data=32'h11 and reg write x3=32'h22, ready low → count=2; entries pop in order mem-write (kind 10, addr 0x10), then reg (kind 01, reg 3).
- Reg write to x0 with FILTER_X0=1 → nothing recorded; with FILTER_X0=0 → kind-01 entry with reg 0.
- DEPTH=16, ready low, 18 single events → count=16, dropped=2, head is still event 1. With STOP_ON_FULL=1 → state=STOPPED after the first drop.
- Full FIFO, out_ready=1 plus one event per cycle for 10 cycles → count stays 16, dropped=0, entries pop in capture order.
- clear while full with simultaneous event and pop → count=0, dropped=0, out_valid=0 next cycle, state still CAPTURE; arm and stop in the same cycle from IDLE → STOPPED.

Source files
------------

// File: rtl/wb_trace_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : wb_trace_buffer
// Brief   : Observer that packs core writeback/memory events into a FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module wb_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 9,
    parameter int FILTER_X0    = 1,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            reg_write_sig,
    input  logic [4:0]                      reg_num,
    input  logic [DATA_W-1:0]               reg_data,
    input  logic                            wr,
    input  logic                            rd,
    input  logic [ADDR_W-1:0]               addr,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic [DATA_W-1:0]               rd_data,
    input  logic                            arm,
    input  logic                            stop,
    input  logic                            clear,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2+5+ADDR_W+DATA_W-1:0]    out_data,
    output logic [$clog2(DEPTH):0]          count,
    output logic [15:0]                     dropped,
    output logic [1:0]                      state
);

    localparam int ENTRY_W = 2 + 5 + ADDR_W + DATA_W;
    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;

    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_CAPTURE = 2'b01;
    localparam logic [1:0] S_STOPPED = 2'b10;

    logic [1:0]         r_state;
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [15:0]        r_dropped;

    logic               w_capture;
    logic               w_mem_ev;
    logic               w_reg_ev;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_mem_entry;
    logic [ENTRY_W-1:0] w_reg_entry;
    logic [ENTRY_W-1:0] w_first;
    logic [CW-1:0]      w_free;
    logic [1:0]         w_n_ev;
    logic [1:0]         w_n_store;
    logic [1:0]         w_n_drop;
    logic [16:0]        w_drop_sum;
    logic [PW-1:0]      w_wptr_nxt;

    assign w_capture   = (r_state == S_CAPTURE);
    assign w_mem_ev    = w_capture & (wr | rd);
    assign w_reg_ev    = w_capture & reg_write_sig & ~((FILTER_X0 != 0) && (reg_num == 5'd0));
    assign w_mem_entry = wr ? {2'b10, 5'd0, addr, wr_data} : {2'b11, 5'd0, addr, rd_data};
    assign w_reg_entry = {2'b01, reg_num, {ADDR_W{1'b0}}, reg_data};
    // The mem event always takes the first slot so it wins when only one fits.
    assign w_first     = w_mem_ev ? w_mem_entry : w_reg_entry;
    assign w_pop       = (r_count != '0) & out_ready;
    assign w_free      = c_depth - r_count + CW'(w_pop);
    assign w_n_ev      = {1'b0, w_mem_ev} + {1'b0, w_reg_ev};
    assign w_n_store   = (w_free >= CW'(w_n_ev)) ? w_n_ev : w_free[1:0];
    assign w_n_drop    = w_n_ev - w_n_store;
    assign w_drop_sum  = {1'b0, r_dropped} + 17'(w_n_drop);
    assign w_wptr_nxt  = r_wptr + PW'(1);

    always_ff @(posedge clk) begin
        if (!clear) begin
            if (w_n_store != 2'd0) r_mem[r_wptr] <= w_first;
            if (w_n_store == 2'd2) r_mem[w_wptr_nxt] <= w_reg_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_dropped <= '0;
        end else if (clear) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_dropped <= '0;
        end else begin
            r_wptr    <= r_wptr + PW'(w_n_store);
            r_rptr    <= r_rptr + PW'(w_pop);
            r_count   <= r_count + CW'(w_n_store) - CW'(w_pop);
            r_dropped <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            if (stop) begin
                r_state <= S_STOPPED;
            end else if (arm && (r_state != S_CAPTURE)) begin
                r_state <= S_CAPTURE;
            end
            if ((STOP_ON_FULL != 0) && !clear && (w_n_drop != 2'd0)) begin
                r_state <= S_STOPPED;
            end
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign count     = r_count;
    assign dropped   = r_dropped;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_wb_trace_buffer
// Brief   : Directed and randomized checks of wb_trace_buffer against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_trace_buffer;

    localparam int DEPTH   = 16;
    localparam int ENTRY_W = 48;
    localparam int PACK_W  = 1 + ENTRY_W + 5 + 16 + 2;

    logic        clk = 1'b0;
    logic        reset, reg_write_sig, wr, rd, arm, stop, clear, out_ready;
    logic [4:0]  reg_num;
    logic [31:0] reg_data, wr_data, rd_data;
    logic [8:0]  addr;

    logic               u0_valid, u1_valid;
    logic [ENTRY_W-1:0] u0_data, u1_data;
    logic [4:0]         u0_count, u1_count;
    logic [15:0]        u0_dropped, u1_dropped;
    logic [1:0]         u0_state, u1_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.DEPTH(16), .DATA_W(32), .ADDR_W(9), .FILTER_X0(1), .STOP_ON_FULL(0)) u0 (
        .clk(clk), .reset(reset), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
        .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .arm(arm), .stop(stop), .clear(clear), .out_valid(u0_valid),
        .out_ready(out_ready), .out_data(u0_data), .count(u0_count), .dropped(u0_dropped),
        .state(u0_state));

    wb_trace_buffer #(.DEPTH(16), .DATA_W(32), .ADDR_W(9), .FILTER_X0(0), .STOP_ON_FULL(1)) u1 (
        .clk(clk), .reset(reset), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
        .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .arm(arm), .stop(stop), .clear(clear), .out_valid(u1_valid),
        .out_ready(out_ready), .out_data(u1_data), .count(u1_count), .dropped(u1_dropped),
        .state(u1_state));

    // Reference model: a queue per instance; index 0 filters x0, index 1 stops on full.
    logic [ENTRY_W-1:0] q0[$];
    logic [ENTRY_W-1:0] q1[$];
    int                 m_st [2];
    int                 m_drop [2];
    logic [ENTRY_W-1:0] ev [2];
    int                 nev, nd;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                if (k == 0) q0.delete(); else q1.delete();
                m_st[k]   = 0;
                m_drop[k] = 0;
            end else begin
                nev = 0;
                nd  = 0;
                if (m_st[k] == 1 && (wr || rd)) begin
                    ev[nev] = wr ? {2'b10, 5'd0, addr, wr_data} : {2'b11, 5'd0, addr, rd_data};
                    nev++;
                end
                if (m_st[k] == 1 && reg_write_sig && !(k == 0 && reg_num == 5'd0)) begin
                    ev[nev] = {2'b01, reg_num, 9'd0, reg_data};
                    nev++;
                end
                if (clear) begin
                    if (k == 0) q0.delete(); else q1.delete();
                    m_drop[k] = 0;
                end else begin
                    if (k == 0 && q0.size() > 0 && out_ready) void'(q0.pop_front());
                    if (k == 1 && q1.size() > 0 && out_ready) void'(q1.pop_front());
                    for (int i = 0; i < nev; i++) begin
                        if (k == 0 && q0.size() < DEPTH) q0.push_back(ev[i]);
                        else if (k == 1 && q1.size() < DEPTH) q1.push_back(ev[i]);
                        else nd++;
                    end
                    m_drop[k] = (m_drop[k] + nd > 65535) ? 65535 : m_drop[k] + nd;
                end
                if (stop) m_st[k] = 2;
                else if (arm && m_st[k] != 1) m_st[k] = 1;
                if (k == 1 && nd > 0) m_st[k] = 2;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reg_write_sig = 0; reg_num = 0; reg_data = 0;
        wr = 0; rd = 0; addr = 0; wr_data = 0; rd_data = 0;
        arm = 0; stop = 0; clear = 0; out_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic arm_both();
        arm = 1;
        tick();
        arm = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (u0_state !== 2'b00) begin errors++; $display("FAIL reset_state got=%0h exp=0", u0_state); end
        if (u0_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", u0_count); end
        if (u0_dropped !== 16'd0) begin errors++; $display("FAIL reset_dropped got=%0d exp=0", u0_dropped); end
        if (u0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", u0_valid); end
        if (u0_data !== 48'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", u0_data); end
    endtask

    task automatic test_single_reg();
        arm_both();
        checks++;
        if (u0_state !== 2'b01) begin errors++; $display("FAIL arm_state got=%0h exp=1", u0_state); end
        reg_write_sig = 1; reg_num = 5'd5; reg_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        checks += 3;
        if (u0_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", u0_valid); end
        if (u0_data !== {2'b01, 5'd5, 9'd0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL single_data got=%h exp=%h", u0_data, {2'b01, 5'd5, 9'd0, 32'hDEADBEEF});
        end
        if (u0_count !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", u0_count); end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks += 2;
        if (u0_count !== 5'd0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", u0_count); end
        if (u0_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got=%b exp=0", u0_valid); end
    endtask

    task automatic test_dual_event();
        wr = 1; addr = 9'h10; wr_data = 32'h11;
        reg_write_sig = 1; reg_num = 5'd3; reg_data = 32'h22;
        tick();
        idle_inputs();
        checks += 2;
        if (u0_count !== 5'd2) begin errors++; $display("FAIL dual_count got=%0d exp=2", u0_count); end
        if (u0_data !== {2'b10, 5'd0, 9'h10, 32'h11}) begin
            errors++; $display("FAIL dual_first got=%h exp=%h", u0_data, {2'b10, 5'd0, 9'h10, 32'h11});
        end
        out_ready = 1;
        tick();
        checks++;
        if (u0_data !== {2'b01, 5'd3, 9'd0, 32'h22}) begin
            errors++; $display("FAIL dual_second got=%h exp=%h", u0_data, {2'b01, 5'd3, 9'd0, 32'h22});
        end
        tick();
        out_ready = 0;
        checks++;
        if (u0_count !== 5'd0) begin errors++; $display("FAIL dual_drain got=%0d exp=0", u0_count); end
    endtask

    task automatic test_x0_filter();
        reg_write_sig = 1; reg_num = 5'd0; reg_data = 32'h55;
        tick();
        idle_inputs();
        checks += 3;
        if (u0_count !== 5'd0) begin errors++; $display("FAIL x0_filtered got=%0d exp=0", u0_count); end
        if (u1_count !== 5'd1) begin errors++; $display("FAIL x0_unfiltered_count got=%0d exp=1", u1_count); end
        if (u1_data !== {2'b01, 5'd0, 9'd0, 32'h55}) begin
            errors++; $display("FAIL x0_unfiltered_data got=%h exp=%h", u1_data, {2'b01, 5'd0, 9'd0, 32'h55});
        end
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_overflow();
        do_reset();
        arm_both();
        for (int i = 0; i < 18; i++) begin
            rd = 1; addr = 9'(i); rd_data = 32'(i + 1);
            tick();
        end
        idle_inputs();
        checks += 6;
        if (u0_count !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", u0_count); end
        if (u0_dropped !== 16'd2) begin errors++; $display("FAIL full_dropped got=%0d exp=2", u0_dropped); end
        if (u0_data !== {2'b11, 5'd0, 9'd0, 32'd1}) begin
            errors++; $display("FAIL full_head got=%h exp=%h", u0_data, {2'b11, 5'd0, 9'd0, 32'd1});
        end
        if (u1_state !== 2'b10) begin errors++; $display("FAIL stop_on_full_state got=%0h exp=2", u1_state); end
        if (u1_dropped !== 16'd1) begin errors++; $display("FAIL stop_on_full_dropped got=%0d exp=1", u1_dropped); end
        if (u1_count !== 5'd16) begin errors++; $display("FAIL stop_on_full_count got=%0d exp=16", u1_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            out_ready = 1; rd = 1; addr = 9'(100 + i); rd_data = 32'(100 + i);
            checks++;
            if (u0_data !== {2'b11, 5'd0, 9'(i), 32'(i + 1)}) begin
                errors++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, u0_data, {2'b11, 5'd0, 9'(i), 32'(i + 1)});
            end
            tick();
            checks += 2;
            if (u0_count !== 5'd16) begin errors++; $display("FAIL b2b_count[%0d] got=%0d exp=16", i, u0_count); end
            if (u0_dropped !== 16'd2) begin errors++; $display("FAIL b2b_dropped[%0d] got=%0d exp=2", i, u0_dropped); end
        end
        idle_inputs();
        checks++;
        if (u0_data !== {2'b11, 5'd0, 9'd10, 32'd11}) begin
            errors++; $display("FAIL b2b_head got=%h exp=%h", u0_data, {2'b11, 5'd0, 9'd10, 32'd11});
        end
    endtask

    task automatic test_clear_and_arm_stop();
        clear = 1; rd = 1; rd_data = 32'h77; out_ready = 1;
        tick();
        idle_inputs();
        checks += 4;
        if (u0_count !== 5'd0) begin errors++; $display("FAIL clear_count got=%0d exp=0", u0_count); end
        if (u0_dropped !== 16'd0) begin errors++; $display("FAIL clear_dropped got=%0d exp=0", u0_dropped); end
        if (u0_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got=%b exp=0", u0_valid); end
        if (u0_state !== 2'b01) begin errors++; $display("FAIL clear_state got=%0h exp=1", u0_state); end
        do_reset();
        arm = 1; stop = 1;
        tick();
        idle_inputs();
        checks++;
        if (u0_state !== 2'b10) begin errors++; $display("FAIL arm_stop_state got=%0h exp=2", u0_state); end
    endtask

    task automatic test_random();
        logic [PACK_W-1:0] obs, exp;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            reset         = ($urandom_range(0, 299) == 0);
            arm           = ($urandom_range(0, 9) == 0);
            stop          = ($urandom_range(0, 39) == 0);
            clear         = ($urandom_range(0, 59) == 0);
            reg_write_sig = $urandom_range(0, 1) == 1;
            reg_num       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            reg_data      = $urandom;
            wr            = ($urandom_range(0, 2) == 0);
            rd            = ($urandom_range(0, 2) == 0);
            addr          = 9'($urandom);
            wr_data       = $urandom;
            rd_data       = $urandom;
            out_ready     = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick();
            obs = {u0_valid, u0_data, u0_count, u0_dropped, u0_state};
            exp = {q0.size() > 0, (q0.size() > 0) ? q0[0] : 48'd0, 5'(q0.size()), 16'(m_drop[0]), 2'(m_st[0])};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL random_u0[%0d] got=%h exp=%h", c, obs, exp); end
            obs = {u1_valid, u1_data, u1_count, u1_dropped, u1_state};
            exp = {q1.size() > 0, (q1.size() > 0) ? q1[0] : 48'd0, 5'(q1.size()), 16'(m_drop[1]), 2'(m_st[1])};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL random_u1[%0d] got=%h exp=%h", c, obs, exp); end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        #2;
        test_reset();
        test_single_reg();
        test_dual_event();
        test_x0_filter();
        test_overflow();
        test_back_to_back();
        test_clear_and_arm_stop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
